// File: rtl/inorder_queue_dispatcher.sv
// inorder_queue_dispatcher
//   Pops one entry at a time from the in-order instruction queue, holds it, and
//   offers it to the functional unit named by its unit-type code through a
//   per-unit valid/ready handshake. Entries with an undefined unit code are
//   dropped with a one-cycle badUnit_o pulse. flush_i overrides every state.
//
//   Unit codes map MSB-first onto issueValid_o / issueReady_i / validUnitMask:
//   code 0 (FX) is bit numUnits-1, code numUnits-1 is bit 0.
//
//   Optional build macro: DISPATCH_STATS_EN adds saturating issued/stall/dropped
//   counters as extra outputs.
module inorder_queue_dispatcher #(
    parameter int unsigned entryWidth       = 256,
    parameter int unsigned funcUnitCodeSize = 3,
    parameter int unsigned numUnits         = 8,
    // MSB-first by code: FX, FP, VX, CR, LS, -, Branch, -
    parameter logic [numUnits-1:0] validUnitMask = 8'b11111010
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        qIsEmpty_i,
    output logic                        qReadEnable_o,
    input  logic [entryWidth-1:0]       qEntry_i,
    input  logic [funcUnitCodeSize-1:0] qFuncUnit_i,
    input  logic                        flush_i,
    output logic [numUnits-1:0]         issueValid_o,
    input  logic [numUnits-1:0]         issueReady_i,
    output logic [entryWidth-1:0]       issueEntry_o,
    output logic                        busy_o,
    output logic                        badUnit_o
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                 issuedCount_o,
    output logic [31:0]                 stallCount_o,
    output logic [15:0]                 droppedCount_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } stateType;

    stateType                    state;
    stateType                    stateNext;
    logic                        waitPhase;
    logic                        waitPhaseNext;
    logic                        qReadEnableNext;
    logic [numUnits-1:0]         issueValidNext;
    logic [entryWidth-1:0]       issueEntryNext;
    logic                        badUnitNext;
    logic [funcUnitCodeSize-1:0] unitBit;
    logic                        codeDefined;
    logic [numUnits-1:0]         codeOneHot;
    logic                        transfer;

    // Decode the presented unit code into its MSB-first port bit.
    always_comb begin
        // numUnits-1-code collapses to a bitwise inversion because numUnits is a power of two
        unitBit             = ~qFuncUnit_i;
        codeDefined         = validUnitMask[unitBit];
        codeOneHot          = '0;
        codeOneHot[unitBit] = 1'b1;
        transfer            = |(issueValid_o & issueReady_i);
    end

    // Next-state and next-output logic; flush overrides every state.
    always_comb begin
        stateNext       = state;
        waitPhaseNext   = waitPhase;
        qReadEnableNext = 1'b0;
        issueValidNext  = issueValid_o;
        issueEntryNext  = issueEntry_o;
        badUnitNext     = 1'b0;

        if (flush_i) begin
            stateNext      = IDLE;
            waitPhaseNext  = 1'b0;
            issueValidNext = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!qIsEmpty_i) begin
                        qReadEnableNext = 1'b1;
                        waitPhaseNext   = 1'b0;
                        stateNext       = WAIT;
                    end
                end
                WAIT: begin
                    if (!waitPhase) begin
                        // first cycle covers the queue's own pop edge
                        waitPhaseNext = 1'b1;
                    end else begin
                        waitPhaseNext = 1'b0;
                        if (codeDefined) begin
                            issueEntryNext = qEntry_i;
                            issueValidNext = codeOneHot;
                            stateNext      = ISSUE;
                        end else begin
                            badUnitNext = 1'b1;
                            stateNext   = IDLE;
                        end
                    end
                end
                ISSUE: begin
                    if (transfer) begin
                        issueValidNext = '0;
                        if (!qIsEmpty_i) begin
                            qReadEnableNext = 1'b1;
                            waitPhaseNext   = 1'b0;
                            stateNext       = WAIT;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
                default: begin
                    stateNext      = IDLE;
                    waitPhaseNext  = 1'b0;
                    issueValidNext = '0;
                end
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= IDLE;
            waitPhase     <= 1'b0;
            qReadEnable_o <= 1'b0;
            issueValid_o  <= '0;
            issueEntry_o  <= '0;
            busy_o        <= 1'b0;
            badUnit_o     <= 1'b0;
        end else begin
            state         <= stateNext;
            waitPhase     <= waitPhaseNext;
            qReadEnable_o <= qReadEnableNext;
            issueValid_o  <= issueValidNext;
            issueEntry_o  <= issueEntryNext;
            busy_o        <= (stateNext != IDLE);
            badUnit_o     <= badUnitNext;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic dropEvent;

    // A drop is a bad-unit discard or a flush that kills an entry not yet taken.
    always_comb begin
        dropEvent = badUnitNext
                  || (flush_i && ((state == WAIT) || ((state == ISSUE) && !transfer)));
    end

    // Saturating statistics counters; only reset clears them.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            issuedCount_o  <= '0;
            stallCount_o   <= '0;
            droppedCount_o <= '0;
        end else begin
            if ((state == ISSUE) && transfer && (issuedCount_o != '1)) begin
                issuedCount_o <= issuedCount_o + 32'd1;
            end
            if ((state == ISSUE) && !transfer && (stallCount_o != '1)) begin
                stallCount_o <= stallCount_o + 32'd1;
            end
            if (dropEvent && (droppedCount_o != '1)) begin
                droppedCount_o <= droppedCount_o + 16'd1;
            end
        end
    end
`endif

endmodule
